uart_fifo_bridge: RTL

Byte-buffering stage between the Forth CPU's UART I/O registers and the simple UART core. TX bytes from the CPU are queued and drained into the UART's write port, honouring its wait handshake. RX bytes are pulled from the UART's single-byte receive holding register as soon as it is valid, so the UART's one-byte buffer is emptied quickly. The CPU side sees two first-word-fall-through FIFOs with status and sticky overflow flags.

---
 rtl/uart_fifo_bridge_pkg.sv | 26 ++
 rtl/uart_fifo_bridge_byte_fifo.sv | 83 ++++++++
 rtl/uart_fifo_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/uart_fifo_bridge_pkg.sv
// Shared constants and helpers for the UART FIFO bridge.
// Contents: byte width, default FIFO depths, the RX hold-warning threshold
// and a saturating increment for the RX hold counter.
package uart_fifo_bridge_pkg;

   localparam int BYTE_W       = 8;
   localparam int TX_DEPTH_DEF = 16;
   localparam int RX_DEPTH_DEF = 16;
   localparam int HOLD_W       = 4;

   // Cycles a received byte may wait on a full RX FIFO before the UART is
   // free to overwrite it.
   localparam logic [HOLD_W-1:0] RX_HOLD_WARN = 4'd15;

   // Increment that sticks at RX_HOLD_WARN.
   function automatic logic [HOLD_W-1:0] sat_inc(input logic [HOLD_W-1:0] v);
      logic [HOLD_W-1:0] r;
      if (v == RX_HOLD_WARN) begin
         r = v;
      end else begin
         r = v + 4'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_fifo_bridge_byte_fifo.sv
// uart_byte_fifo: first-word-fall-through byte FIFO on a circular RAM.
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   push, din      - write request and data (dropped when full)
//   pop            - consume head (ignored when empty)
//   dout           - current head, forced to 0 while empty
//   full, empty    - status from the registered pointers
//   count          - occupancy (wptr - rptr)
module uart_byte_fifo
   import uart_fifo_bridge_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [BYTE_W-1:0] din,
   output logic [BYTE_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [AW:0]       count
);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       rptr_q, rptr_d;
   logic              push_ok_s;
   logic              pop_ok_s;

   // Status, accepted operations and next pointers.
   always_comb begin
      // Pointers carry one extra wrap bit so full and empty are distinct.
      empty     = (wptr_q == rptr_q);
      full      = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      count     = wptr_q - rptr_q;
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      if (push_ok_s) begin
         wptr_d = wptr_q + 1'b1;
      end else begin
         wptr_d = wptr_q;
      end
      if (pop_ok_s) begin
         rptr_d = rptr_q + 1'b1;
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Asynchronous head read; zero while empty so reset shows a clean 0.
   always_comb begin
      dout = '0;
      if (empty) begin
         dout = '0;
      end else begin
         dout = mem_q[rptr_q[AW-1:0]];
      end
   end

   // Pointer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage; contents need no reset because empty masks the output.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: byte buffering between the CPU UART registers and the
// UART core.  TX bytes drain into the UART write port under uart_wait; RX
// bytes are pulled out of the UART holding register as soon as possible.
// Ports:
//   clk, reset                       - clock, synchronous active-high reset
//   cpu_tx_we/data, cpu_tx_full/empty - CPU transmit side
//   cpu_rx_re, cpu_rx_data/avail     - CPU receive side (FWFT)
//   cpu_flag_clr, tx/rx_overflow     - sticky error flags and their clear
//   uart_we/di/wait                  - UART write port
//   uart_re/do/rx_valid              - UART receive port
module uart_fifo_bridge
   import uart_fifo_bridge_pkg::*;
#(
   parameter int TX_DEPTH = TX_DEPTH_DEF,
   parameter int RX_DEPTH = RX_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_tx_we,
   input  logic [BYTE_W-1:0] cpu_tx_data,
   output logic              cpu_tx_full,
   output logic              cpu_tx_empty,
   input  logic              cpu_rx_re,
   output logic [BYTE_W-1:0] cpu_rx_data,
   output logic              cpu_rx_avail,
   input  logic              cpu_flag_clr,
   output logic              tx_overflow,
   output logic              rx_overflow,
   output logic              uart_we,
   output logic [BYTE_W-1:0] uart_di,
   input  logic              uart_wait,
   output logic              uart_re,
   input  logic [BYTE_W-1:0] uart_do,
   input  logic              uart_rx_valid
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [RX_AW:0] RX_CNT_FULL = (RX_AW+1)'(RX_DEPTH);

   logic              tx_full_s, tx_empty_s, tx_pop_s;
   logic [TX_AW:0]    tx_count_s;
   logic              rx_full_s, rx_empty_s, rx_push_s, rx_hold_s;
   logic [RX_AW:0]    rx_count_s;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              tx_ovf_q, tx_ovf_d;
   logic              rx_ovf_q, rx_ovf_d;

   uart_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (cpu_tx_we),
      .pop   (tx_pop_s),
      .din   (cpu_tx_data),
      .dout  (uart_di),
      .full  (tx_full_s),
      .empty (tx_empty_s),
      .count (tx_count_s)
   );

   uart_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push_s),
      .pop   (cpu_rx_re),
      .din   (uart_do),
      .dout  (cpu_rx_data),
      .full  (rx_full_s),
      .empty (rx_empty_s),
      .count (rx_count_s)
   );

   // Handshake glue between the FIFOs and the UART ports.
   always_comb begin
      uart_we      = !tx_empty_s;
      tx_pop_s     = uart_we && !uart_wait;
      cpu_tx_full  = tx_full_s;
      // Nothing is written to the UART while the queue is empty, so empty
      // here already means "idle this cycle".
      cpu_tx_empty = (tx_count_s == '0);
      uart_re      = uart_rx_valid && !rx_full_s;
      rx_push_s    = uart_re;
      cpu_rx_avail = !rx_empty_s;
   end

   // Hold counter and sticky flags; a set condition beats the clear.
   always_comb begin
      rx_hold_s  = uart_rx_valid && (rx_count_s == RX_CNT_FULL);
      hold_cnt_d = '0;
      tx_ovf_d   = tx_ovf_q;
      rx_ovf_d   = rx_ovf_q;
      if (rx_hold_s) begin
         hold_cnt_d = sat_inc(hold_cnt_q);
      end else begin
         hold_cnt_d = '0;
      end
      if (cpu_tx_we && tx_full_s) begin
         tx_ovf_d = 1'b1;
      end else if (cpu_flag_clr) begin
         tx_ovf_d = 1'b0;
      end else begin
         tx_ovf_d = tx_ovf_q;
      end
      // Flag rises on the edge where the counter reaches the threshold.
      if (hold_cnt_d == RX_HOLD_WARN) begin
         rx_ovf_d = 1'b1;
      end else if (cpu_flag_clr) begin
         rx_ovf_d = 1'b0;
      end else begin
         rx_ovf_d = rx_ovf_q;
      end
   end

   // Flag and hold-counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold_cnt_q <= '0;
         tx_ovf_q   <= 1'b0;
         rx_ovf_q   <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_ovf_q   <= rx_ovf_d;
      end
   end

   assign tx_overflow = tx_ovf_q;
   assign rx_overflow = rx_ovf_q;

endmodule
